pll_lock_ctrl: RTL

PLL_LOCK_CTRL -- requirements
Module: pll_lock_ctrl

---
 rtl/pll_lock_ctrl.sv | 99 +++++++++
 1 files changed

// File: rtl/pll_lock_ctrl.sv
// pll_lock_ctrl: PLL reset/lock sequencer (clk, reset, pll_locked, req_relock -> pll_rst, sys_reset_out, lock_lost, fault, relock_count, state_dbg)
module pll_lock_ctrl #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 1048575,
  parameter int STABLE_CYCLES = 1024,
  parameter int MAX_RETRY     = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pll_locked,
  input  logic       req_relock,
  output logic       pll_rst,
  output logic       sys_reset_out,
  output logic       lock_lost,
  output logic       fault,
  output logic [7:0] relock_count,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {
    PLL_RST   = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAULT     = 3'd4
  } state_t;
  state_t      state, state_n;
  logic [19:0] cnt, cnt_n;
  logic [3:0]  retry, retry_n;
  logic [1:0]  sync;
  logic        locked_s, lose;
  assign locked_s  = sync[1];
  assign lose      = state == RUN && !locked_s;
  assign state_dbg = state;
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 20'd1;
    retry_n = retry;
    case (state)
      PLL_RST: if (cnt == 20'(RST_CYCLES - 1)) begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end
      WAIT_LOCK: if (locked_s) begin
        state_n = STABLE;
        cnt_n   = '0;
      end else if (cnt == 20'(LOCK_TIMEOUT - 1)) begin
        retry_n = retry + 4'd1;
        state_n = (retry_n == 4'(MAX_RETRY)) ? FAULT : PLL_RST;
        cnt_n   = '0;
      end
      STABLE: if (!locked_s) begin
        state_n = WAIT_LOCK;
        cnt_n   = '0;
      end else if (cnt == 20'(STABLE_CYCLES - 1)) begin
        state_n = RUN;
        cnt_n   = '0;
        retry_n = '0;
      end
      RUN: begin
        cnt_n   = '0;
        state_n = (!locked_s || req_relock) ? PLL_RST : RUN;
      end
      FAULT: begin
        cnt_n   = '0;
        state_n = req_relock ? PLL_RST : FAULT;
        retry_n = req_relock ? 4'd0 : retry;
      end
      default: begin
        state_n = PLL_RST;
        cnt_n   = '0;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= PLL_RST;
      cnt           <= '0;
      retry         <= '0;
      sync          <= '0;
      pll_rst       <= 1'b1;
      sys_reset_out <= 1'b1;
      fault         <= 1'b0;
      lock_lost     <= 1'b0;
      relock_count  <= '0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      retry         <= retry_n;
      sync          <= {sync[0], pll_locked};
      pll_rst       <= state_n == PLL_RST;
      sys_reset_out <= state_n != RUN;
      fault         <= state_n == FAULT;
      if (lose) begin
        lock_lost    <= 1'b1;
        relock_count <= relock_count + 8'(relock_count != 8'hff);
      end
    end
  end
endmodule
